// File: rtl/pipeline_debug_unit.sv
// Debug controller for the pipeline freeze line: runs, single-steps or halts the pipeline from
// UART command bytes and streams a frozen snapshot of the pipeline state back out as bytes.
module pipeline_debug_unit #(
  parameter int unsigned N_WORDS  = 4,
  parameter logic [7:0]  CMD_RUN  = 8'h52,
  parameter logic [7:0]  CMD_STEP = 8'h53,
  parameter logic [7:0]  CMD_DUMP = 8'h44,
  parameter logic [7:0]  CMD_HALT = 8'h48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    halt_in,
  input  logic [32*N_WORDS-1:0]   dump_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    stop_debug,
  output logic                    step_done,
  output logic                    busy
);

  localparam int unsigned N_BYTES = 4 * N_WORDS;
  localparam int unsigned CNT_W   = (N_BYTES > 2) ? $clog2(N_BYTES) : 1;
  localparam int unsigned SNAP_W  = 32 * N_WORDS;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DUMP = 2'd3
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  byte_cnt_q;
  logic [CNT_W-1:0]  byte_cnt_d;
  logic [SNAP_W-1:0] snap_q;
  logic [7:0]        next_byte_c;

  // Byte that follows the one currently on tx_data; word 0 first, each word LSB first.
  assign byte_cnt_d  = byte_cnt_q + CNT_W'(1);
  assign next_byte_c = snap_q[{byte_cnt_d, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      snap_q     <= '0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      stop_debug <= 1'b1;
      step_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_RUN) begin
              state_q    <= ST_RUN;
              stop_debug <= 1'b0;
              busy       <= 1'b1;
            end else if (rx_data == CMD_STEP) begin
              state_q    <= ST_STEP;
              stop_debug <= 1'b0;
              busy       <= 1'b1;
            end else if (rx_data == CMD_DUMP) begin
              // Snapshot is frozen here; later dump_data changes never reach the output.
              state_q    <= ST_DUMP;
              snap_q     <= dump_data;
              tx_data    <= dump_data[7:0];
              tx_valid   <= 1'b1;
              byte_cnt_q <= '0;
              busy       <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (halt_in || (rx_valid && (rx_data == CMD_HALT))) begin
            state_q    <= ST_IDLE;
            stop_debug <= 1'b1;
            busy       <= 1'b0;
          end
        end

        ST_STEP: begin
          state_q    <= ST_IDLE;
          stop_debug <= 1'b1;
          step_done  <= 1'b1;
          busy       <= 1'b0;
        end

        ST_DUMP: begin
          // tx_data only advances on a completed handshake, so it holds while stalled.
          if (tx_ready) begin
            if (byte_cnt_q == LAST_BYTE) begin
              state_q    <= ST_IDLE;
              tx_valid   <= 1'b0;
              byte_cnt_q <= '0;
              busy       <= 1'b0;
            end else begin
              byte_cnt_q <= byte_cnt_d;
              tx_data    <= next_byte_c;
            end
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          stop_debug <= 1'b1;
          tx_valid   <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_debug_unit.sv
// Self-checking bench for pipeline_debug_unit: directed vector table, dump/run/reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_pipeline_debug_unit;

  localparam int unsigned N_WORDS = 4;
  localparam int unsigned N_BYTES = 4 * N_WORDS;
  localparam logic [7:0] C_R = 8'h52;
  localparam logic [7:0] C_S = 8'h53;
  localparam logic [7:0] C_D = 8'h44;
  localparam logic [7:0] C_H = 8'h48;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  halt_in;
  logic [32*N_WORDS-1:0] dump_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  stop_debug;
  logic                  step_done;
  logic                  busy;

  pipeline_debug_unit #(.N_WORDS(N_WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .halt_in   (halt_in),
    .dump_data (dump_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .stop_debug(stop_debug),
    .step_done (step_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic h, input logic tr);
    rx_valid = v;
    rx_data  = d;
    halt_in  = h;
    tx_ready = tr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    chk({name, "_stop"}, 32'(stop_debug), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_txv"},  32'(tx_valid), 32'd0);
  endtask

  // Directed vectors: inputs applied for one edge, outputs expected just after that edge.
  typedef struct {
    logic       rv;
    logic [7:0] rd;
    logic       h;
    logic       tr;
    logic       stop;
    logic       bsy;
    logic       txv;
    logic       sd;
  } vec_t;

  vec_t tbl [19];

  // Reference model: operating mode plus a queue of bytes still owed to the transmitter.
  typedef enum int {M_IDLE, M_RUN, M_STEP, M_DUMP} mode_e;
  mode_e      m_mode;
  logic       m_sd;
  logic [7:0] m_q [$];

  task automatic model_edge(input logic rv, input logic [7:0] rd, input logic h, input logic tr,
                            input logic [32*N_WORDS-1:0] dd);
    m_sd = 1'b0;
    case (m_mode)
      M_IDLE: if (rv) begin
        if (rd == C_R) m_mode = M_RUN;
        else if (rd == C_S) m_mode = M_STEP;
        else if (rd == C_D) begin
          m_q.delete();
          for (int k = 0; k < N_BYTES; k++) m_q.push_back(dd[8*k +: 8]);
          m_mode = M_DUMP;
        end
      end
      M_RUN:  if (h || (rv && rd == C_H)) m_mode = M_IDLE;
      M_STEP: begin m_mode = M_IDLE; m_sd = 1'b1; end
      M_DUMP: if (tr) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  logic [32*N_WORDS-1:0] dd_fix;
  logic [7:0]            exp_b [N_BYTES];

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, C_H,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, C_S,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, C_R,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, C_R,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, C_S,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, C_D,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, C_H,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, C_R,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, C_H,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, C_S,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b1, C_S,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    dd_fix = {32'h00FFEEDD, 32'hCCBBAA99, 32'h88776655, 32'h44332211};
    exp_b  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};

    // Reset state
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    dump_data = dd_fix;
    tick(); tick();
    check_idle("rst_held");
    chk("rst_step_done", 32'(step_done), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();
    check_idle("idle_no_rx");

    // Directed table
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rv, tbl[i].rd, tbl[i].h, tbl[i].tr);
      tick();
      chk($sformatf("vec%0d_stop", i), 32'(stop_debug), 32'(tbl[i].stop));
      chk($sformatf("vec%0d_busy", i), 32'(busy),       32'(tbl[i].bsy));
      chk($sformatf("vec%0d_txv", i),  32'(tx_valid),   32'(tbl[i].txv));
      chk($sformatf("vec%0d_sd", i),   32'(step_done),  32'(tbl[i].sd));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Back-to-back dump with tx_ready held high
    drive(1'b1, C_D, 1'b0, 1'b1);
    tick();
    rx_valid = 1'b0;
    for (int i = 0; i < N_BYTES; i++) begin
      chk($sformatf("dump_fast_v%0d", i), 32'(tx_valid), 32'd1);
      chk($sformatf("dump_fast_b%0d", i), 32'(tx_data), 32'(exp_b[i]));
      chk($sformatf("dump_fast_stop%0d", i), 32'(stop_debug), 32'd1);
      tick();
    end
    check_idle("dump_fast_end");

    // Stalled dump, dump_data altered mid-stream
    drive(1'b1, C_D, 1'b0, 1'b0);
    tick();
    rx_valid = 1'b0;
    begin
      int idx;
      idx = 0;
      for (int c = 0; c < 100 && idx < N_BYTES; c++) begin
        tx_ready = c[0];
        if (c == 3) dump_data = ~dd_fix;
        chk($sformatf("dump_stall_v%0d", c), 32'(tx_valid), 32'd1);
        chk($sformatf("dump_stall_b%0d", c), 32'(tx_data), 32'(exp_b[idx]));
        if (tx_ready) idx++;
        tick();
      end
      chk("dump_stall_count", 32'(idx), 32'(N_BYTES));
    end
    check_idle("dump_stall_end");
    dump_data = dd_fix;
    tx_ready  = 1'b0;

    // Run until halt_in
    drive(1'b1, C_R, 1'b0, 1'b0);
    tick();
    rx_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("run_stop%0d", i), 32'(stop_debug), 32'd0);
      tick();
    end
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    check_idle("run_halt");
    tick();
    check_idle("run_halt_after");

    // Run, then 'H' coinciding with halt_in
    drive(1'b1, C_R, 1'b0, 1'b0);
    tick();
    rx_valid = 1'b0;
    tick(); tick();
    chk("run2_stop", 32'(stop_debug), 32'd0);
    drive(1'b1, C_H, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_idle("run2_halt");
    chk("run2_step_done", 32'(step_done), 32'd0);
    tick();
    check_idle("run2_after");

    // Async reset after 5 bytes, then restart from byte 0
    drive(1'b1, C_D, 1'b0, 1'b1);
    tick();
    rx_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_mid_b5", 32'(tx_data), 32'(exp_b[5]));
    #2;
    rst = 1'b1;
    #1;
    check_idle("rst_mid");
    #3;
    rst = 1'b0;
    tx_ready = 1'b0;
    tick();
    check_idle("rst_mid_release");
    drive(1'b1, C_D, 1'b0, 1'b0);
    tick();
    rx_valid = 1'b0;
    chk("dump_restart_v", 32'(tx_valid), 32'd1);
    chk("dump_restart_b0", 32'(tx_data), 32'(exp_b[0]));
    tx_ready = 1'b1;
    tick();
    chk("dump_restart_b1", 32'(tx_data), 32'(exp_b[1]));

    // Randomized traffic against the reference model
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_mode = M_IDLE;
    m_sd   = 1'b0;
    m_q.delete();
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic                  rv, h, tr;
      logic [7:0]            rd;
      logic [32*N_WORDS-1:0] dd;
      int                    pick;
      rv   = ($urandom_range(3) == 0);
      pick = int'($urandom_range(4));
      case (pick)
        0:       rd = C_R;
        1:       rd = C_S;
        2:       rd = C_D;
        3:       rd = C_H;
        default: rd = 8'($urandom);
      endcase
      h  = ($urandom_range(15) == 0);
      tr = 1'($urandom_range(1));
      for (int k = 0; k < N_WORDS; k++) dd[32*k +: 32] = $urandom;
      drive(rv, rd, h, tr);
      dump_data = dd;
      tick();
      model_edge(rv, rd, h, tr, dd);
      chk("rnd_stop", 32'(stop_debug), 32'((m_mode == M_RUN || m_mode == M_STEP) ? 1'b0 : 1'b1));
      chk("rnd_busy", 32'(busy), 32'((m_mode != M_IDLE) ? 1'b1 : 1'b0));
      chk("rnd_txv", 32'(tx_valid), 32'((m_mode == M_DUMP) ? 1'b1 : 1'b0));
      chk("rnd_sd", 32'(step_done), 32'(m_sd));
      if (m_mode == M_DUMP) chk("rnd_txd", 32'(tx_data), 32'(m_q[0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
